// File: rtl/spi_frame_tx_if.sv
// Bus bundle between spi_frame_tx, its upstream 4:1 mux and the SPI link.
// The master modport is the transmitter's view; slave is the environment's view.
interface spi_frame_tx_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 start;
    logic [1:0]           mux_ctl;
    logic [BUS_WIDTH-1:0] mux_data;
    logic                 spi_sclk;
    logic                 spi_mosi;
    logic                 spi_cs_n;
    logic                 busy;
    logic                 done;

    modport master (
        input  start,
        input  mux_data,
        output mux_ctl,
        output spi_sclk,
        output spi_mosi,
        output spi_cs_n,
        output busy,
        output done
    );

    modport slave (
        output start,
        output mux_data,
        input  mux_ctl,
        input  spi_sclk,
        input  spi_mosi,
        input  spi_cs_n,
        input  busy,
        input  done
    );
endinterface

// File: rtl/spi_frame_tx.sv
// Frame sequencer + SPI mode-0 serialiser: walks mux_ctl over FRAME_WORDS words under one cs_n.
// Define SPI_LSB_FIRST_EN to shift each word LSB first; default build is MSB first.
module spi_frame_tx #(
    parameter int BUS_WIDTH   = 8,
    parameter int CLK_DIV     = 4,
    parameter int FRAME_WORDS = 4
) (
    input logic            clk,
    input logic            rst,
    spi_frame_tx_if.master bus
);
    localparam int BIT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BUS_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [1:0]       WORD_LAST = 2'(FRAME_WORDS - 1);
`ifdef SPI_LSB_FIRST_EN
    localparam int OUT_BIT = 0;
`else
    localparam int OUT_BIT = BUS_WIDTH - 1;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_t;

    state_t               state_q, state_d;
    logic [1:0]           mux_ctl_q, mux_ctl_d;
    logic [1:0]           word_q, word_d;
    logic [BUS_WIDTH-1:0] shift_q, shift_d;
    logic [BUS_WIDTH-1:0] shifted;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mux_ctl_q <= '0;
            word_q    <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_ctl_q <= mux_ctl_d;
            word_q    <= word_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mux_ctl_d = mux_ctl_q;
        word_d    = word_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        shifted   = shift_q >> 1;
`else
        shifted   = shift_q << 1;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mux_ctl_d = '0;
                    word_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                shift_d = bus.mux_data;
                mosi_d  = bus.mux_data[OUT_BIT];
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
                bit_d   = '0;
                div_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_q == DIV_MAX) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Only the falling edge advances the bit/word position.
                    if (sclk_q) begin
                        if (bit_q != BIT_LAST) begin
                            shift_d = shifted;
                            mosi_d  = shifted[OUT_BIT];
                            bit_d   = bit_q + 1'b1;
                        end else if (word_q != WORD_LAST) begin
                            mux_ctl_d = mux_ctl_q + 2'd1;
                            word_d    = word_q + 2'd1;
                            state_d   = LOAD;
                        end else begin
                            state_d = TAIL;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TAIL: begin
                if (div_q == DIV_MAX) begin
                    div_d     = '0;
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    mux_ctl_d = '0;
                    word_d    = '0;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mux_ctl  = mux_ctl_q;
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: a CLK_DIV=2/4-word instance and a CLK_DIV=1/2-word instance.
// Expected MOSI streams follow SPI_LSB_FIRST_EN when it is defined for the build.
module tb_spi_frame_tx;
    localparam int CD_A = 2;

`ifdef SPI_LSB_FIRST_EN
    localparam logic [31:0] EXP_A = 32'h833CFF00;
    localparam logic [31:0] EXP_B = 32'h0000833C;
`else
    localparam logic [31:0] EXP_A = 32'hC13CFF00;
    localparam logic [31:0] EXP_B = 32'h0000C13C;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t0 = 0;
    int   rel = 0;

    spi_frame_tx_if #(.BUS_WIDTH(8)) ifa ();
    spi_frame_tx_if #(.BUS_WIDTH(8)) ifb ();

    spi_frame_tx #(.BUS_WIDTH(8), .CLK_DIV(CD_A), .FRAME_WORDS(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    spi_frame_tx #(.BUS_WIDTH(8), .CLK_DIV(1), .FRAME_WORDS(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    function automatic logic [7:0] muxWord(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'hC1;
            2'd1:    return 8'h3C;
            2'd2:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    assign ifa.mux_data = muxWord(ifa.mux_ctl);
    assign ifb.mux_data = muxWord(ifb.mux_ctl);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for instance A, sampled on the falling clk edge.
    logic        mon_clr = 1'b0;
    logic        prev_sclk, prev_mosi, prev_cs_n;
    logic [1:0]  prev_mux;
    logic [31:0] rx;
    logic [7:0]  mux_seq;
    int rise_cnt, gap_n, gap_w, gap_bad, hi_run, hi_bad, mosi_bad, done_cnt;
    int last_rise, cs_fall_cyc, cs_rise_cyc, mux_chg_cnt, mux_first_cyc;

    always @(negedge clk) begin
        if (mon_clr) begin
            rise_cnt = 0; gap_n = 0; gap_w = 0; gap_bad = 0; hi_run = 0; hi_bad = 0;
            mosi_bad = 0; done_cnt = 0; last_rise = -1; cs_fall_cyc = -1; cs_rise_cyc = -1;
            mux_chg_cnt = 0; mux_first_cyc = -1; rx = '0; mux_seq = '0;
        end else begin
            if (ifa.spi_sclk && !prev_sclk) begin
                rise_cnt++;
                rx = {rx[30:0], ifa.spi_mosi};
                if (last_rise >= 0) begin
                    if (cyc - last_rise == 2 * CD_A) gap_n++;
                    else if (cyc - last_rise == 2 * CD_A + 1) gap_w++;
                    else gap_bad++;
                end
                last_rise = cyc;
            end
            if (ifa.spi_sclk) begin
                hi_run++;
                if (prev_sclk && ifa.spi_mosi !== prev_mosi) mosi_bad++;
            end else if (prev_sclk) begin
                if (hi_run != CD_A) hi_bad++;
                hi_run = 0;
            end
            if (ifa.done) done_cnt++;
            if (!ifa.spi_cs_n && prev_cs_n) cs_fall_cyc = cyc;
            if (ifa.spi_cs_n && !prev_cs_n) cs_rise_cyc = cyc;
            if (ifa.mux_ctl != prev_mux) begin
                if (mux_chg_cnt == 0) mux_first_cyc = cyc;
                mux_chg_cnt++;
                mux_seq = {mux_seq[5:0], ifa.mux_ctl};
            end
        end
        prev_sclk = ifa.spi_sclk;
        prev_mosi = ifa.spi_mosi;
        prev_cs_n = ifa.spi_cs_n;
        prev_mux  = ifa.mux_ctl;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearMon();
        @(posedge clk);
        #1 mon_clr = 1'b1;
        @(posedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        ifa.start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    // Returns the done edge relative to the start-sampling edge, or -1 on timeout.
    task automatic waitDone(output int rel_edge);
        rel_edge = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) begin
                rel_edge = cyc - t0;
                break;
            end
        end
        if (rel_edge < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic runNormalFrame(input string tag);
        clearMon();
        applyStimulus();
        while (cyc - t0 < 10) @(negedge clk);
        checkOutput({tag, "_busy_mid"}, 32'(ifa.busy), 32'd1);
        checkOutput({tag, "_csn_mid"}, 32'(ifa.spi_cs_n), 32'd0);
        waitDone(rel);
        checkOutput({tag, "_done_edge"}, rel, 32'd134);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_rises"}, rise_cnt, 32'd32);
        checkOutput({tag, "_mosi"}, rx, EXP_A);
        checkOutput({tag, "_gap_in_word"}, gap_n, 32'd28);
        checkOutput({tag, "_gap_word_bdy"}, gap_w, 32'd3);
        checkOutput({tag, "_gap_other"}, gap_bad, 32'd0);
        checkOutput({tag, "_high_width"}, hi_bad, 32'd0);
        checkOutput({tag, "_mosi_stable"}, mosi_bad, 32'd0);
        checkOutput({tag, "_done_count"}, done_cnt, 32'd1);
        checkOutput({tag, "_csn_fall"}, cs_fall_cyc - t0, 32'd1);
        checkOutput({tag, "_csn_rise"}, cs_rise_cyc - t0, 32'd134);
        checkOutput({tag, "_mux_seq"}, 32'(mux_seq), 32'h6C);
        checkOutput({tag, "_mux_first"}, mux_first_cyc - t0, 32'd33);
        checkOutput({tag, "_busy_end"}, 32'(ifa.busy), 32'd0);
    endtask

    initial begin
        int         rb_cnt;
        int         done_b_rel;
        logic [31:0] rb;
        logic [3:0] mseq_b;
        logic       pb_sclk;
        logic [1:0] pb_mux;

        ifa.start = 1'b0;
        ifb.start = 1'b0;
        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("rst_csn", 32'(ifa.spi_cs_n), 32'd1);
        checkOutput("rst_sclk", 32'(ifa.spi_sclk), 32'd0);
        checkOutput("rst_mosi", 32'(ifa.spi_mosi), 32'd0);
        checkOutput("rst_busy", 32'(ifa.busy), 32'd0);
        checkOutput("rst_done", 32'(ifa.done), 32'd0);
        checkOutput("rst_mux", 32'(ifa.mux_ctl), 32'd0);
        checkOutput("rst_b_csn", 32'(ifb.spi_cs_n), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] single frame, CLK_DIV=2, 4 words");
        runNormalFrame("f1");

        $display("[TB] two-word frame, CLK_DIV=1");
        rb_cnt = 0; rb = '0; mseq_b = '0; done_b_rel = -1;
        pb_sclk = ifb.spi_sclk; pb_mux = ifb.mux_ctl;
        @(negedge clk);
        ifb.start = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            if (ifb.spi_sclk && !pb_sclk) begin
                rb_cnt++;
                rb = {rb[30:0], ifb.spi_mosi};
            end
            if (ifb.mux_ctl != pb_mux) mseq_b = {mseq_b[1:0], ifb.mux_ctl};
            if (ifb.done === 1'b1) done_b_rel = cyc - t0;
            pb_sclk = ifb.spi_sclk;
            pb_mux  = ifb.mux_ctl;
        end
        checkOutput("b_rises", rb_cnt, 32'd16);
        checkOutput("b_mosi", rb, EXP_B);
        checkOutput("b_done_edge", done_b_rel, 32'd35);
        checkOutput("b_mux_seq", 32'(mseq_b), 32'h4);

        $display("[TB] start held high across two frames");
        clearMon();
        @(negedge clk);
        ifa.start = 1'b1;
        t0 = cyc + 1;
        waitDone(rel);
        checkOutput("hold_done1", rel, 32'd134);
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (60) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        waitDone(rel);
        checkOutput("hold_done2", rel, 32'd269);
        repeat (150) @(negedge clk);
        checkOutput("hold_done_count", done_cnt, 32'd2);
        checkOutput("hold_rises", rise_cnt, 32'd64);
        checkOutput("hold_mosi", rx, EXP_A);
        checkOutput("hold_csn_fall2", cs_fall_cyc - t0, 32'd136);
        checkOutput("hold_idle_csn", 32'(ifa.spi_cs_n), 32'd1);

        $display("[TB] reset at edge 50 of a frame");
        clearMon();
        applyStimulus();
        while (cyc - t0 < 49) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_csn", 32'(ifa.spi_cs_n), 32'd1);
        checkOutput("abort_sclk", 32'(ifa.spi_sclk), 32'd0);
        checkOutput("abort_busy", 32'(ifa.busy), 32'd0);
        checkOutput("abort_mux", 32'(ifa.mux_ctl), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        checkOutput("abort_no_done", done_cnt, 32'd0);
        checkOutput("abort_rises", rise_cnt, 32'd12);
        runNormalFrame("f2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
